ro_freq_counter: RTL and testbench

Measurement stage directly downstream of the OSU ring-oscillator wrapper. It takes the five oscillator outputs (X1_Y1..X5_Y1) and selects one. It enables the oscillator, counts rising edges of the selected output over a programmable window of system-clock cycles, and presents the count to the management side through a valid/ready handshake. It also drives the oscillator `start` input, so the oscillator runs only while a measurement is in progress.

---
 rtl/ro_meas_pkg.sv | 14 +
 rtl/ro_sync_edge.sv | 30 +++
 rtl/ro_freq_counter.sv | 116 +++++++++++
 tb/tb_ro_freq_counter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_GATE   = 2'd2,
    ST_HOLD   = 2'd3
  } ro_state_e;

  localparam int SETTLE_DEFAULT = 4;
  localparam int SYNC_DEPTH     = 2;

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for an asynchronous oscillator output, followed by a
// registered rising-edge detector (three cycles from input edge to pulse).
import ro_meas_pkg::*;

module ro_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;
  logic                  stable;

  assign stable = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      prev_q <= stable;
      rise   <= stable & ~prev_q;
    end
  end

endmodule

// File: rtl/ro_freq_counter.sv
// Gated rising-edge counter for one selected ring-oscillator output.
// Optional feature: RO_FREQ_CNT_SAT_EN (saturating count + overflow flag).
import ro_meas_pkg::*;

module ro_freq_counter #(
  parameter int NUM_RO = 5,
  parameter int SEL_W  = 3,
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16,
  parameter int SETTLE = SETTLE_DEFAULT
) (
`ifdef USE_POWER_PINS
  inout  wire               vccd1,
  inout  wire               vssd1,
`endif
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NUM_RO-1:0] ro_in,
  input  logic [SEL_W-1:0]  ro_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              meas_start,
  output logic              ro_en,
  output logic              busy,
  output logic              cnt_valid,
  input  logic              cnt_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [1:0]        fsm_state
);

  // Handshake: the result in count is transferred in any cycle where
  // cnt_valid and cnt_ready are both high; count is stable while cnt_valid.

  ro_state_e         state;
  logic [GATE_W-1:0] timer;
  logic [GATE_W-1:0] gate_q;
  logic [SEL_W-1:0]  sel_q;
  logic              ovf_q;
  logic              ro_mux;
  logic              rise;
  logic              accept;

  // Out-of-range selects fall through to a constant 0.
  always_comb begin
    ro_mux = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (sel_q == SEL_W'(i)) ro_mux = ro_in[i];
    end
  end

  ro_sync_edge u_sync_edge (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (ro_mux),
    .rise (rise)
  );

  assign accept = meas_start &&
                  (state == ST_IDLE || (state == ST_HOLD && cnt_ready));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      timer  <= '0;
      gate_q <= '0;
      sel_q  <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      state  <= ST_WARMUP;
      timer  <= GATE_W'(SETTLE - 1);
      gate_q <= gate_cycles;
      sel_q  <= ro_sel;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (timer == '0) begin
            if (gate_q == '0) begin
              state <= ST_HOLD;
            end else begin
              state <= ST_GATE;
              timer <= gate_q - 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GATE: begin
          if (rise) begin
`ifdef RO_FREQ_CNT_SAT_EN
            if (&count) ovf_q <= 1'b1;
            else        count <= count + 1'b1;
`else
            count <= count + 1'b1;
`endif
          end
          if (timer == '0) state <= ST_HOLD;
          else             timer <= timer - 1'b1;
        end
        ST_HOLD: begin
          if (cnt_ready) state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign ro_en     = (state == ST_WARMUP) || (state == ST_GATE);
  assign busy      = (state != ST_IDLE);
  assign cnt_valid = (state == ST_HOLD);
  assign overflow  = ovf_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: a default instance and a CNT_W=4 instance
// share all inputs; the narrow one exercises wrap/saturation.
import ro_meas_pkg::*;

module tb_ro_freq_counter;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ro_in = '0;
  logic [2:0]  ro_sel = '0;
  logic [15:0] gate_cycles = '0;
  logic        meas_start = 1'b0;
  logic        cnt_ready = 1'b0;

  logic        ro_en, busy, cnt_valid, overflow;
  logic [15:0] count;
  logic [1:0]  fsm_state;

  logic        ro_en4, busy4, cnt_valid4, overflow4;
  logic [3:0]  count4;
  logic [1:0]  fsm_state4;

  int total = 0;
  int bad   = 0;
  int ro_mode = 0;
  int phase = 0;

  always #5 clk = ~clk;

  // Oscillator model: mode 1 = ro_in[2] with 8-cycle period,
  // mode 2 = all bits with 2-cycle period, otherwise quiet.
  always @(posedge clk) begin
    #2;
    phase = phase + 1;
    ro_in = '0;
    if (ro_mode == 1) ro_in[2] = phase[2];
    else if (ro_mode == 2) ro_in = {5{phase[0]}};
  end

  ro_freq_counter dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .ro_in       (ro_in),
    .ro_sel      (ro_sel),
    .gate_cycles (gate_cycles),
    .meas_start  (meas_start),
    .ro_en       (ro_en),
    .busy        (busy),
    .cnt_valid   (cnt_valid),
    .cnt_ready   (cnt_ready),
    .count       (count),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  ro_freq_counter #(.CNT_W(4)) dut4 (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .ro_in       (ro_in),
    .ro_sel      (ro_sel),
    .gate_cycles (gate_cycles),
    .meas_start  (meas_start),
    .ro_en       (ro_en4),
    .busy        (busy4),
    .cnt_valid   (cnt_valid4),
    .cnt_ready   (cnt_ready),
    .count       (count4),
    .overflow    (overflow4),
    .fsm_state   (fsm_state4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns in cycle T+1.
  task automatic start_meas(input logic [2:0] sel, input logic [15:0] n);
    ro_sel      = sel;
    gate_cycles = n;
    meas_start  = 1'b1;
    tick();
    meas_start  = 1'b0;
  endtask

  // lat = cycles after T at which cnt_valid is first seen; en = ro_en cycles before it.
  task automatic wait_valid(input int lat0, output int lat, output int en);
    lat = lat0;
    en  = 0;
    while (cnt_valid !== 1'b1 && lat < 300) begin
      if (ro_en === 1'b1) en++;
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
  endtask

  int lat, en;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ro_en", ro_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", cnt_valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", fsm_state, ST_IDLE);
    rst = 1'b0;
    tick();

    // A: select 2, 8-cycle period, N=64
    ro_mode = 1;
    repeat (3) tick();
    start_meas(3'd2, 16'd64);
    check("a_busy_t1", busy, 1);
    check("a_ro_en_t1", ro_en, 1);
    check("a_state_t1", fsm_state, ST_WARMUP);
    wait_valid(1, lat, en);
    check("a_latency", lat, SETTLE + 65);
    check("a_count", count, 8);
    check("a_overflow", overflow, 0);
    check("a_ro_en_hold", ro_en, 0);
    check("a_ro_en_cycles", en, SETTLE + 64);
    handshake();
    check("a_valid_after_hs", cnt_valid, 0);
    check("a_busy_after_hs", busy, 0);
    check("a_count_kept", count, 8);

    // B: N=0
    start_meas(3'd2, 16'd0);
    wait_valid(1, lat, en);
    check("b_latency", lat, SETTLE + 1);
    check("b_count", count, 0);
    check("b_ro_en_cycles", en, SETTLE);
    handshake();

    // C: 2-cycle period, N=64, default and 4-bit counters
    ro_mode = 2;
    repeat (3) tick();
    start_meas(3'd0, 16'd64);
    wait_valid(1, lat, en);
    check("c_latency", lat, SETTLE + 65);
    check("c_count16", count, 32);
    check("c_overflow16", overflow, 0);
    check("c_valid4", cnt_valid4, 1);
`ifdef RO_FREQ_CNT_SAT_EN
    check("c_count4_sat", count4, 15);
    check("c_overflow4_sat", overflow4, 1);
`else
    check("c_count4_wrap", count4, 0);
    check("c_overflow4_wrap", overflow4, 0);
`endif
    handshake();

    // D: starts during GATE and during HOLD without handshake are ignored
    ro_mode = 1;
    repeat (3) tick();
    start_meas(3'd2, 16'd64);
    repeat (9) tick();
    check("d_state_gate", fsm_state, ST_GATE);
    ro_sel      = 3'd0;
    gate_cycles = 16'd5;
    meas_start  = 1'b1;
    tick();
    meas_start  = 1'b0;
    wait_valid(11, lat, en);
    check("d_latency", lat, SETTLE + 65);
    check("d_count", count, 8);
    repeat (3) tick();
    meas_start = 1'b1;
    tick();
    meas_start = 1'b0;
    repeat (6) tick();
    check("d_hold_valid", cnt_valid, 1);
    check("d_hold_state", fsm_state, ST_HOLD);
    check("d_hold_count", count, 8);
    ro_sel      = 3'd2;
    gate_cycles = 16'd16;
    cnt_ready   = 1'b1;
    meas_start  = 1'b1;
    tick();
    cnt_ready   = 1'b0;
    meas_start  = 1'b0;
    check("d_restart_busy", busy, 1);
    check("d_restart_valid", cnt_valid, 0);
    check("d_restart_state", fsm_state, ST_WARMUP);
    check("d_restart_count", count, 0);
    wait_valid(1, lat, en);
    check("d2_latency", lat, SETTLE + 17);
    check("d2_count", count, 2);
    handshake();

    // E: reset in the middle of GATE, then a clean measurement
    start_meas(3'd2, 16'd64);
    repeat (20) tick();
    check("e_state_gate", fsm_state, ST_GATE);
    rst = 1'b1;
    tick();
    check("e_rst_ro_en", ro_en, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_valid", cnt_valid, 0);
    check("e_rst_count", count, 0);
    check("e_rst_state", fsm_state, ST_IDLE);
    rst = 1'b0;
    tick();
    start_meas(3'd2, 16'd32);
    wait_valid(1, lat, en);
    check("e_latency", lat, SETTLE + 33);
    check("e_count", count, 4);
    handshake();

    // F: out-of-range select with every input toggling
    ro_mode = 2;
    repeat (3) tick();
    start_meas(3'd6, 16'd32);
    wait_valid(1, lat, en);
    check("f_latency", lat, SETTLE + 33);
    check("f_count", count, 0);
    handshake();
    check("f_idle", fsm_state, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
